// File: rtl/mix_columns_engine.sv
// mix_columns_engine: handshaked AES MixColumns / InvMixColumns over a
// 128-bit state, COLS_PER_CYCLE columns per clock (1, 2 or 4).
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_state/in_inv
// input handshake; out_valid/out_ready/out_state output handshake; busy.
// Optional macro MIXCOL_BYPASS_EN adds in_bypass (copy columns unchanged).
// Column c lives in bits [127-32c -: 32], row 0 is the column's MSB byte.
module mix_columns_engine #(
   parameter int COLS_PER_CYCLE = 1,
   parameter int STATE_W        = 128
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_state,
   input  logic               in_inv,
`ifdef MIXCOL_BYPASS_EN
   input  logic               in_bypass,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_state,
   output logic               busy
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
         COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
   end

   if (STATE_W != 128) begin : g_bad_width
      $error("STATE_W must be 128");
   end

   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_e;

   state_e               state_q, state_d;
   logic [1:0]           cnt_q, cnt_d;
   logic                 inv_q, inv_d;
   logic                 ovld_q, ovld_d;
   logic [STATE_W-1:0]   work_q, work_d;
   logic [STATE_W-1:0]   out_q, out_d;
   logic [STATE_W-1:0]   work_nxt;
`ifdef MIXCOL_BYPASS_EN
   logic                 byp_q, byp_d;
`endif

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // One column through the forward or inverse coefficient matrix.
   // Every multiple is an XOR of the x2/x4/x8 xtime chain.
   function automatic logic [31:0] mix_col(input logic [31:0] col,
                                           input logic        inv);
      logic [7:0]  a  [4];
      logic [7:0]  x2 [4];
      logic [7:0]  x4 [4];
      logic [7:0]  x8 [4];
      logic [7:0]  m3 [4];
      logic [7:0]  m9 [4];
      logic [7:0]  mb [4];
      logic [7:0]  md [4];
      logic [7:0]  me [4];
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2[i] = xt(a[i]);
         x4[i] = xt(x2[i]);
         x8[i] = xt(x4[i]);
         m3[i] = x2[i] ^ a[i];
         m9[i] = x8[i] ^ a[i];
         mb[i] = x8[i] ^ x2[i] ^ a[i];
         md[i] = x8[i] ^ x4[i] ^ a[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
      res = '0;
      for (int r = 0; r < 4; r++) begin
         if (inv) begin
            res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^
                               md[(r+2)%4] ^ m9[(r+3)%4];
         end else begin
            res[31-8*r -: 8] = x2[r] ^ m3[(r+1)%4] ^
                               a[(r+2)%4] ^ a[(r+3)%4];
         end
      end
      return res;
   endfunction

   // Working register with the current column group replaced.
   // Groups are aligned, so cnt_q + j never wraps inside a group.
   always_comb begin
      work_nxt = work_q;
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         logic [1:0]  idx;
         logic [31:0] col;
         logic [31:0] res;
         int          base;
         idx  = cnt_q + 2'(j);
         base = (3 - int'(idx)) * 32;
         col  = work_q[base +: 32];
         res  = mix_col(col, inv_q);
`ifdef MIXCOL_BYPASS_EN
         if (byp_q) begin
            res = col;
         end
`endif
         work_nxt[base +: 32] = res;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inv_d   = inv_q;
      ovld_d  = ovld_q;
      work_d  = work_q;
      out_d   = out_q;
`ifdef MIXCOL_BYPASS_EN
      byp_d   = byp_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               work_d  = in_state;
               inv_d   = in_inv;
`ifdef MIXCOL_BYPASS_EN
               byp_d   = in_bypass;
`endif
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            work_d = work_nxt;
            out_d  = work_nxt;
            cnt_d  = cnt_q + CNT_STEP;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               ovld_d  = 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
               ovld_d  = 1'b0;
               cnt_d   = 2'd0;
            end
         end
         default: begin
            state_d = S_IDLE;
            ovld_d  = 1'b0;
            cnt_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         inv_q   <= 1'b0;
         ovld_q  <= 1'b0;
         work_q  <= '0;
         out_q   <= '0;
`ifdef MIXCOL_BYPASS_EN
         byp_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inv_q   <= inv_d;
         ovld_q  <= ovld_d;
         work_q  <= work_d;
         out_q   <= out_d;
`ifdef MIXCOL_BYPASS_EN
         byp_q   <= byp_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = ovld_q;
   assign out_state = out_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: three engines (1, 2, 4 columns per cycle)
// checked against a GF(2^8) matrix reference model.
module tb_mix_columns_engine;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] in_state;
   logic         in_inv;
`ifdef MIXCOL_BYPASS_EN
   logic         in_bypass;
`endif
   logic [2:0]   in_valid;
   logic [2:0]   in_ready;
   logic [2:0]   out_valid;
   logic [2:0]   out_ready;
   logic [2:0]   busy;
   logic [127:0] out_state [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_engine #(
         .COLS_PER_CYCLE(1 << g),
         .STATE_W(128)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .in_valid(in_valid[g]),
         .in_ready(in_ready[g]),
         .in_state(in_state),
         .in_inv(in_inv),
`ifdef MIXCOL_BYPASS_EN
         .in_bypass(in_bypass),
`endif
         .out_valid(out_valid[g]),
         .out_ready(out_ready[g]),
         .out_state(out_state[g]),
         .busy(busy[g])
      );
   end

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Polynomial product reduced modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a,
                                       input logic [7:0] b);
      logic [14:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p ^= 15'(a) << i;
      for (int i = 14; i >= 8; i--)
         if (p[i]) p ^= 15'h11b << (i - 8);
      return p[7:0];
   endfunction

   function automatic logic [127:0] model(input logic [127:0] st,
                                          input logic inv);
      logic [7:0]   row0 [4];
      logic [7:0]   acc;
      logic [127:0] res;
      if (inv) row0 = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int k = 0; k < 4; k++)
               acc ^= gmul(row0[(k - r + 4) % 4],
                           st[127 - 32*c - 8*k -: 8]);
            res[127 - 32*c - 8*r -: 8] = acc;
         end
      return res;
   endfunction

   task automatic run(input int k, input logic [127:0] st,
                      input logic inv, input int hold,
                      input logic flip, input logic [127:0] exp,
                      input string tag);
      int lat;
      @(negedge clk);
      chk({tag, " in_ready idle"}, 128'(in_ready[k]), 128'(1));
      in_state    = st;
      in_inv      = inv;
      in_valid[k] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[k] = 1'b0;
      in_state    = ~st;
      if (flip) in_inv = ~inv;
      lat = 0;
      while (!out_valid[k] && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, " latency"}, 128'(lat), 128'(4 >> k));
      chk({tag, " out_state"}, out_state[k], exp);
      chk({tag, " busy done"}, 128'(busy[k]), 128'(1));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         in_valid[k] = (h == 1);
         @(posedge clk);
         #1;
         chk({tag, " hold valid"}, 128'(out_valid[k]), 128'(1));
         chk({tag, " hold state"}, out_state[k], exp);
         chk({tag, " hold in_ready"}, 128'(in_ready[k]), 128'(0));
      end
      @(negedge clk);
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, " release valid"}, 128'(out_valid[k]), 128'(0));
      chk({tag, " release in_ready"}, 128'(in_ready[k]), 128'(1));
      chk({tag, " idle hold state"}, out_state[k], exp);
      @(negedge clk);
      out_ready[k] = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [127:0] v1_in, v1_out, v2_in, v2_out, st;
      logic         inv;
      int           k;
      v1_in  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      v1_out = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
      v2_in  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
      v2_out = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

      rst       = 1'b1;
      in_valid  = '0;
      out_ready = '0;
      in_state  = '0;
      in_inv    = 1'b0;
`ifdef MIXCOL_BYPASS_EN
      in_bypass = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
         chk("reset in_ready", 128'(in_ready[g]), 128'(1));
         chk("reset out_valid", 128'(out_valid[g]), 128'(0));
         chk("reset out_state", out_state[g], 128'(0));
         chk("reset busy", 128'(busy[g]), 128'(0));
      end
      @(negedge clk);
      rst = 1'b0;

      run(0, v1_in, 1'b0, 0, 1'b0, v1_out, "fwd n1");
      run(1, v2_in, 1'b1, 0, 1'b0, v2_out, "inv n2");
      run(2, v1_in, 1'b0, 5, 1'b0, v1_out, "bp n4");
      run(0, v1_in, 1'b0, 1, 1'b1, v1_out, "freeze n1");

      // Abort on the second BUSY cycle.
      @(negedge clk);
      in_state    = v2_in;
      in_inv      = 1'b1;
      in_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort in_ready", 128'(in_ready[0]), 128'(1));
      chk("abort out_valid", 128'(out_valid[0]), 128'(0));
      chk("abort out_state", out_state[0], 128'(0));
      chk("abort busy", 128'(busy[0]), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      run(0, v2_in, 1'b1, 0, 1'b0, v2_out, "after abort");

      for (int i = 0; i < 24; i++) begin
         k   = int'($urandom_range(0, 2));
         st  = {$urandom, $urandom, $urandom, $urandom};
         inv = 1'($urandom_range(0, 1));
         run(k, st, inv, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), model(st, inv), "rand");
      end

`ifdef MIXCOL_BYPASS_EN
      in_bypass = 1'b1;
      st = 128'h00112233_44556677_8899aabb_ccddeeff;
      for (int g = 0; g < 3; g++) begin
         run(g, st, 1'b0, 1, 1'b0, st, "bypass fwd");
         run(g, st, 1'b1, 0, 1'b0, st, "bypass inv");
      end
      in_bypass = 1'b0;
      run(1, v1_in, 1'b0, 0, 1'b0, v1_out, "bypass off");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Sequential, handshaked MixColumns / InvMixColumns unit for a full 128-bit AES state, shared by the encrypt and decrypt datapaths.
- Processes COLS_PER_CYCLE columns per clock. Total compute takes 4/COLS_PER_CYCLE cycles.
- GF(2^8) products use xtime chains, not lookup tables.
- Sits between the ShiftRows/InvShiftRows stage and AddRoundKey in the iterative round controller.

Parameters:
- COLS_PER_CYCLE, 1, number of columns transformed per cycle. Legal values are 1, 2, 4; any other value is an elaboration error.
- STATE_W, 128, state width. Fixed at 128; the parameter exists for port declarations only.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input state valid.
- in_ready  out  1  engine can accept a state.
- in_state  in  128  input state. Column c is in bits [127-32c : 96-32c]; within a column, row 0 is the MSB byte.
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns. Sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_state  out  128  transformed state, same layout as in_state.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset values (clock edge with rst=1):
  - state = IDLE
  - out_valid = 0, out_state = 0, busy = 0
  - column counter = 0, captured mode = 0
  - in_ready = 1 after reset, since it is decoded from IDLE.
- FSM:
  - IDLE: in_ready = 1. When in_valid=1, capture in_state into the working register and in_inv into the mode register, then go to BUSY. The counter is already 0 in IDLE.
  - BUSY: in_ready = 0. Each cycle, replace columns [counter .. counter+COLS_PER_CYCLE-1] in the working register with their transformed values, and advance the counter by COLS_PER_CYCLE. After the group containing column 3, go to DONE and set out_valid = 1.
  - DONE: out_valid = 1 and out_state = working register, both held stable until out_ready=1. On the cycle with out_valid && out_ready, go to IDLE, clear out_valid and reset the counter to 0.
- Latency: out_valid rises 4/COLS_PER_CYCLE cycles after the accept edge (4, 2 or 1). Minimum initiation interval is 4/COLS_PER_CYCLE + 2 cycles.
- in_ready is combinational from state only, never from in_valid or out_ready. An input presented while not IDLE is ignored and not captured.
- out_state holds its last value in IDLE and changes only in BUSY.
- Arithmetic, per column bytes a0..a3:
  - x2 = xtime(a) = (a<<1) ^ (a[7] ? 8'h1b : 0)
  - x4 = xtime(x2), x8 = xtime(x4)
  - Forward coefficient rows are rotations of {2,3,1,1}; 3a = x2^a.
  - Inverse coefficient rows are rotations of {e,b,d,9}:
    - 9a = x8^a
    - ba = x8^x2^a
    - da = x8^x4^a
    - ea = x8^x4^x2
  - Row r output = XOR of its four products. All arithmetic is 8-bit; no carries leave a byte.
- Mode is frozen at accept. Toggling in_inv during BUSY or DONE has no effect.
- Reset mid-operation (rst=1 in BUSY or DONE): the operation is aborted and the result discarded. The next cycle is IDLE with all outputs at their reset values.
- out_ready high while out_valid=0 has no effect.

Optional Feature:
- Macro: MIXCOL_BYPASS_EN.
- When defined:
  - Adds input port in_bypass (1 bit), sampled at accept.
  - If the captured bypass bit is 1, BUSY copies the columns unchanged. This serves the final AES round.
  - FSM sequence, latency and handshake are identical to the non-bypass case.
- When undefined:
  - The port is absent and no bypass logic is built.

Test Plan:
- Forward, COLS_PER_CYCLE=1, in_state={db135345, f20a225c, 01010101, c6c6c6c6}, in_inv=0 -> out_state={8e4da1bc, 9fdc589d, 01010101, c6c6c6c6}; out_valid rises 4 cycles after accept.
- Inverse, COLS_PER_CYCLE=2, in_state={8e4da1bc, 9fdc589d, d5d5d7d6, 4d7ebdf8}, in_inv=1 -> out_state={db135345, f20a225c, d4d4d4d5, 2d26314c}; latency 2 cycles.
- Backpressure, COLS_PER_CYCLE=4: hold out_ready=0 for 5 cycles -> out_valid and out_state stay stable, in_ready=0 throughout; a second in_valid pulse during this time is ignored. Output is released on the first cycle with out_ready=1.
- Reset mid-BUSY: assert rst on the 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, out_state=0. A fresh accept then yields the correct result.
- Mode freeze: accept with in_inv=0, flip in_inv to 1 during BUSY -> result equals the forward transform.
- MIXCOL_BYPASS_EN defined, in_bypass=1, in_state=00112233_44556677_8899aabb_ccddeeff -> out_state identical to in_state, same latency as the non-bypass case.
